// File: rtl/sw_input_conditioner_if.sv
// Switch-side bundle for sw_input_conditioner: raw switches in, debounced switches and SW8 strobes out.
// master = switch/board side (drives SW_raw), slave = conditioner (drives the cleaned outputs).
interface sw_input_conditioner_if;
    logic [8:0] SW_raw;
    logic [8:0] SW_clean;
    logic       SW8_rise;
    logic       SW8_fall;

    modport master (
        output SW_raw,
        input  SW_clean,
        input  SW8_rise,
        input  SW8_fall
    );

    modport slave (
        input  SW_raw,
        output SW_clean,
        output SW8_rise,
        output SW8_fall
    );
endinterface

// File: rtl/sw_input_conditioner.sv
// Synchronise and debounce the nine picomips slide switches, with SW8 edge strobes.
// Optional macro SW_DATA_FREEZE_EN: hold SW_clean[7:0] stable while SW_clean[8] is high.
module sw_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   Clock,
    input  logic                   nReset,
    sw_input_conditioner_if.slave  sw
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [8:0]       sync_q [SYNC_STAGES];
    logic [8:0]       sync_w;
    logic [CNT_W-1:0] cnt_q  [9];
    logic [CNT_W-1:0] cnt_d  [9];
    logic [8:0]       clean_q;
    logic [8:0]       clean_d;
    logic             rise_q;
    logic             fall_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= sw.SW_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    // Count consecutive mismatches; a match anywhere restarts the count, so glitches never accumulate.
    always_comb begin
        clean_d = clean_q;
        for (int i = 0; i < 9; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_w[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                clean_d[i] = sync_w[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < 9; i++) begin
                cnt_q[i] <= '0;
            end
            clean_q <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            clean_q <= clean_d;
            rise_q  <= clean_d[8] & ~clean_q[8];
            fall_q  <= ~clean_d[8] & clean_q[8];
        end
    end

    assign sw.SW8_rise = rise_q;
    assign sw.SW8_fall = fall_q;

`ifdef SW_DATA_FREEZE_EN
    logic [7:0] hold_q;

    // Capture the data debounced on the same edge SW8 goes high so the core reads one stable value.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            hold_q <= '0;
        end else if (clean_d[8] && !clean_q[8]) begin
            hold_q <= clean_d[7:0];
        end
    end

    assign sw.SW_clean = {clean_q[8], clean_q[8] ? hold_q : clean_q[7:0]};
`else
    assign sw.SW_clean = clean_q;
`endif

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Self-checking bench for sw_input_conditioner: directed scenarios plus randomized switch activity vs a window model.
module tb_sw_input_conditioner;
    localparam int S = 2;
    localparam int D = 4;

    logic Clock  = 1'b0;
    logic nReset = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    sw_input_conditioner_if sw_if ();

    sw_input_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .sw     (sw_if.slave)
    );

    initial forever #5 Clock = ~Clock;

    // Model: a bit flips when the last D synchronised samples all disagree with it.
    logic [8:0] hist [$];
    logic [8:0] m_live = '0;
    logic [7:0] m_hold = '0;
    logic       m_rise = 1'b0;
    logic       m_fall = 1'b0;
    logic [8:0] m_out;

    always @(posedge Clock or negedge nReset) begin
        logic [8:0] nxt;
        logic       all_diff;
        if (!nReset) begin
            hist = {};
            for (int j = 0; j < S + D; j++) hist.push_back(9'h000);
            m_live = '0;
            m_hold = '0;
            m_rise = 1'b0;
            m_fall = 1'b0;
        end else begin
            hist.push_back(sw_if.SW_raw);
            void'(hist.pop_front());
            nxt = m_live;
            for (int i = 0; i < 9; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (hist[j][i] == m_live[i]) all_diff = 1'b0;
                end
                if (all_diff) nxt[i] = ~m_live[i];
            end
            m_rise = nxt[8] & ~m_live[8];
            m_fall = ~nxt[8] & m_live[8];
            if (m_rise) m_hold = nxt[7:0];
            m_live = nxt;
        end
    end

`ifdef SW_DATA_FREEZE_EN
    assign m_out = {m_live[8], m_live[8] ? m_hold : m_live[7:0]};
`else
    assign m_out = m_live;
`endif

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        check("clean", sw_if.SW_clean, m_out);
        check("rise", {8'h00, sw_if.SW8_rise}, {8'h00, m_rise});
        check("fall", {8'h00, sw_if.SW8_fall}, {8'h00, m_fall});
        check("rise_fall_excl", {8'h00, sw_if.SW8_rise & sw_if.SW8_fall}, 9'h000);
    end

    task automatic drive(input logic [8:0] v);
        @(negedge Clock);
        #2;
        sw_if.SW_raw = v;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic release_reset();
        @(negedge Clock);
        #2;
        nReset = 1'b1;
    endtask

    initial begin
        int cnt;
        int rise_cnt;
        int fall_cnt;
        int rise_at;
        int fall_at;
        logic [8:0] v;
        int hold;

        sw_if.SW_raw = 9'h1FF;

        // Reset with all switches high, then power-up latency
        wait_n(3);
        check("reset_clean", sw_if.SW_clean, 9'h000);
        check("reset_rise", {8'h00, sw_if.SW8_rise}, 9'h000);
        check("reset_fall", {8'h00, sw_if.SW8_fall}, 9'h000);
        release_reset();
        wait_n(5);
        check("release_k4", sw_if.SW_clean, 9'h000);
        wait_n(1);
        check("release_k5", sw_if.SW_clean, 9'h1FF);
        check("model_release_k5", m_out, 9'h1FF);
        check("release_rise", {8'h00, sw_if.SW8_rise}, 9'h001);
        wait_n(1);
        check("release_rise_end", {8'h00, sw_if.SW8_rise}, 9'h000);

        // Clean step on bit 0
        drive(9'h000);
        wait_n(12);
        drive(9'h001);
        wait_n(5);
        check("step_k4", sw_if.SW_clean, 9'h000);
        wait_n(1);
        check("step_k5", sw_if.SW_clean, 9'h001);
        check("model_step_k5", m_out, 9'h001);

        // 3-cycle glitch on bit 3 is rejected
        drive(9'h009);
        wait_n(2);
        drive(9'h001);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clock);
            if (sw_if.SW_clean[3]) cnt++;
        end
        check("glitch3_cycles", 9'(cnt), 9'd0);

        // 4-cycle pulse passes as a 4-cycle pulse
        drive(9'h009);
        wait_n(3);
        drive(9'h001);
        cnt = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge Clock);
            if (sw_if.SW_clean[3]) cnt++;
        end
        check("pulse4_cycles", 9'(cnt), 9'd4);

        // Handshake: SW8 high for 20 sampled cycles
        drive(9'h000);
        wait_n(10);
        drive(9'h100);
        rise_cnt = 0; fall_cnt = 0; rise_at = -1; fall_at = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clock);
            if (sw_if.SW8_rise) begin rise_cnt++; rise_at = c; end
            if (sw_if.SW8_fall) begin fall_cnt++; fall_at = c; end
            if (c == 19) begin #2; sw_if.SW_raw = 9'h000; end
        end
        check("hs_rise_count", 9'(rise_cnt), 9'd1);
        check("hs_fall_count", 9'(fall_cnt), 9'd1);
        check("hs_rise_at", 9'(rise_at), 9'd5);
        check("hs_spacing", 9'(fall_at - rise_at), 9'd20);

        // Data freeze while SW8 high
        drive(9'h05A);
        wait_n(10);
        drive(9'h15A);
        wait_n(10);
        drive(9'h1C3);
        wait_n(8);
`ifdef SW_DATA_FREEZE_EN
        check("freeze_held", {1'b0, sw_if.SW_clean[7:0]}, 9'h05A);
`else
        check("freeze_live", {1'b0, sw_if.SW_clean[7:0]}, 9'h0C3);
`endif
        drive(9'h0C3);
        wait_n(8);
        check("freeze_after", sw_if.SW_clean, 9'h0C3);

        // Reset mid-count on bit 1
        drive(9'h000);
        wait_n(10);
        drive(9'h002);
        wait_n(4);
        #2;
        nReset = 1'b0;
        #1;
        check("midreset_clean", sw_if.SW_clean, 9'h000);
        release_reset();
        wait_n(5);
        check("midreset_k4", sw_if.SW_clean, 9'h000);
        wait_n(1);
        check("midreset_k5", sw_if.SW_clean, 9'h002);

        // Randomized switch activity
        for (int seg = 0; seg < 400; seg++) begin
            case ($urandom_range(0, 3))
                0: v = 9'($urandom_range(0, 511));
                1: v = sw_if.SW_raw ^ (9'h001 << $urandom_range(0, 8));
                2: v = sw_if.SW_raw ^ 9'h100;
                default: v = sw_if.SW_raw ^ 9'($urandom_range(0, 511));
            endcase
            hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12);
            drive(v);
            wait_n(hold - 1);
            if ($urandom_range(0, 49) == 0) begin
                @(negedge Clock);
                #3;
                nReset = 1'b0;
                release_reset();
            end
        end
        wait_n(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sw_input_conditioner.md
Name: sw_input_conditioner

Overview:
- Front-end stage directly upstream of the picomips core. Sits between the raw board slide switches and the core's SW[8:0] input.
- Synchronises raw SW[8:0] to Clock and debounces each bit independently.
- Produces one-cycle edge strobes for the SW8 handshake switch.
- SW[9] is the core's nReset; it is not routed through this block.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per bit (legal range >= 2).
- DEBOUNCE_CYCLES, 4, consecutive mismatching cycles needed before a clean bit changes (legal range >= 1).

Ports:
- Clock  input  1  system clock, rising-edge active.
- nReset  input  1  asynchronous, active-low reset.
- SW_raw  input  9  raw board switches; bit 8 is the handshake switch, bits 7:0 are data.
- SW_clean  output  9  debounced switches; drives picomips SW[8:0].
- SW8_rise  output  1  one-cycle strobe when SW_clean[8] goes 0->1.
- SW8_fall  output  1  one-cycle strobe when SW_clean[8] goes 1->0.

Behaviour:
- Clock and reset: one clock domain, Clock. Reset is asynchronous and active-low on nReset.
- Reset values: all synchroniser flops, debounce counters, SW_clean, SW8_rise and SW8_fall are 0. Reset asserted mid-operation clears all state immediately. Release is synchronous to the next Clock edge.
- Synchroniser: SW_raw[i] passes through SYNC_STAGES flops. The output is sync[i].
- Debounce, per bit i, with a counter of width clog2(DEBOUNCE_CYCLES), minimum 1 bit:
  - If sync[i] == SW_clean[i]: counter is cleared to 0.
  - Else if counter == DEBOUNCE_CYCLES-1: SW_clean[i] <= sync[i] and counter is cleared.
  - Else: counter increments.
- Latency: raw change first sampled at edge k and held stable -> SW_clean changes at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults this is edge k+5.
- Glitch rejection: any return of sync to the clean value before the count completes restarts the count from 0. A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never reaches SW_clean.
- Bit independence: the nine bits are debounced independently with no cross-bit ordering. Simultaneous raw changes on several bits update on the same edge if they were sampled on the same edge.
- Edge strobes: registered. SW8_rise is high for exactly the one cycle following the edge at which SW_clean[8] became 1; SW8_fall likewise for the 1->0 transition. Rise and fall are never high together.
- Power-up with switch high: if SW_raw[8]=1 at reset release, SW_clean[8] rises after the latency above and SW8_rise fires once.
- DEBOUNCE_CYCLES=1: the clean bit follows sync with one register delay. No glitch filtering beyond synchronisation.
- Counter saturation: a counter never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.

Optional Feature:
- Macro: SW_DATA_FREEZE_EN.
- Defined:
  - SW_clean[7:0] is captured into a hold register at the same edge SW_clean[8] becomes 1.
  - While SW_clean[8]=1, SW_clean[7:0] outputs the held value and ignores further debounced data changes.
  - When SW_clean[8] returns to 0, the output reverts to the live debounced data on that edge.
  - The hold register resets to 0.
  - Purpose: guarantees the core's MOV from register 1 sees data stable for the whole SW8-high phase.
- Undefined: SW_clean[7:0] is always the live debounced data and no hold register exists.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset: hold nReset=0 with SW_raw=9'h1FF -> SW_clean=0, SW8_rise=SW8_fall=0. Release -> SW_clean=9'h1FF exactly 5 edges after the first sampling edge, plus one SW8_rise pulse.
- Clean step: SW_raw[0] 0->1 before edge k, held -> SW_clean[0]=1 after edge k+5, not before. SW8 strobes stay 0.
- Glitch: SW_raw[3] high for 3 cycles then low -> SW_clean[3] stays 0 throughout. A 4-cycle pulse -> SW_clean[3] pulses high for 4 cycles.
- Handshake: SW_raw[8] 0->1, held 20 cycles, then 1->0 -> exactly one SW8_rise, then exactly one SW8_fall, each 1 cycle wide, 20 cycles apart.
- Freeze (SW_DATA_FREEZE_EN defined): SW_raw[7:0]=8'h5A, raise SW8, then change data to 8'hC3 -> SW_clean[7:0]=8'h5A while SW_clean[8]=1. After SW8 falls it shows 8'hC3. With the macro undefined it shows 8'hC3 after 5 edges.
- Reset mid-count: SW_raw[1] toggled, nReset pulsed low at count 2 -> SW_clean[1]=0, counter restarts, and a full 5-edge latency applies after release.
